// File: rtl/compare_minmax_tracker.sv
// compare_minmax_tracker: running unsigned min/max of A, signed min/max
// of C and a saturating sample count, read out through a snapshot port.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   in_valid/in_ready   operand handshake; in_a unsigned, in_c signed
//   clear               synchronous flush of all accumulated state
//   snap_req            request a snapshot; results appear next cycle
//   snap_valid          snapshot outputs valid
//   min_u/max_u         snapshot unsigned extremes of A
//   min_s/max_s         snapshot signed extremes of C
//   count/sat           snapshot sample count and saturation flag
//
// Optional macro MINMAX_INDEX_EN adds idx_min_u/idx_max_u/idx_min_s/
// idx_max_s: acceptance index of the sample holding each extreme.

module compare_minmax_tracker #(
  parameter int WIDTH = 64,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_c,
  input  logic             clear,
  input  logic             snap_req,
  output logic             snap_valid,
  output logic [WIDTH-1:0] min_u,
  output logic [WIDTH-1:0] max_u,
  output logic [WIDTH-1:0] min_s,
  output logic [WIDTH-1:0] max_s,
  output logic [CNT_W-1:0] count,
  output logic             sat
`ifdef MINMAX_INDEX_EN
  ,
  output logic [CNT_W-1:0] idx_min_u,
  output logic [CNT_W-1:0] idx_max_u,
  output logic [CNT_W-1:0] idx_min_s,
  output logic [CNT_W-1:0] idx_max_s
`endif
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE =
    {{(CNT_W-1){1'b0}}, 1'b1};

  localparam logic [WIDTH-1:0] UMIN_INIT = '1;
  localparam logic [WIDTH-1:0] UMAX_INIT = '0;
  localparam logic [WIDTH-1:0] SMIN_INIT =
    {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SMAX_INIT =
    {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    ST_EMPTY,
    ST_ACTIVE,
    ST_SAT
  } state_t;

  state_t state_q, state_d;

  // ---------------- input handshake ----------------
  // rdy_q blocks the cycle after clear; clear/rst themselves
  // mask in_ready combinationally in their own cycle.
  logic rdy_q;
  logic accept;

  always_ff @(posedge clk) begin
    if (rst) begin
      rdy_q <= 1'b1;
    end else if (clear) begin
      rdy_q <= 1'b0;
    end else begin
      rdy_q <= 1'b1;
    end
  end

  assign in_ready = rdy_q & ~rst & ~clear;
  assign accept   = in_valid & in_ready;

  // ---------------- S1: operand register ----------------
  logic             s1_vld_q;
  logic [WIDTH-1:0] s1_a_q;
  logic [WIDTH-1:0] s1_c_q;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      s1_vld_q <= 1'b0;
    end else begin
      s1_vld_q <= accept;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_a_q <= '0;
      s1_c_q <= '0;
    end else if (accept) begin
      s1_a_q <= in_a;
      s1_c_q <= in_c;
    end
  end

  // ---------------- S2: accumulators ----------------
  logic [WIDTH-1:0] mnu_q, mnu_d;
  logic [WIDTH-1:0] mxu_q, mxu_d;
  logic [WIDTH-1:0] mns_q, mns_d;
  logic [WIDTH-1:0] mxs_q, mxs_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

`ifdef MINMAX_INDEX_EN
  logic [CNT_W-1:0] imnu_q, imnu_d;
  logic [CNT_W-1:0] imxu_q, imxu_d;
  logic [CNT_W-1:0] imns_q, imns_d;
  logic [CNT_W-1:0] imxs_q, imxs_d;
`endif

  // Strict compares: a tie never replaces the stored value.
  logic a_lt, a_gt, c_lt, c_gt;

  assign a_lt = s1_a_q < mnu_q;
  assign a_gt = s1_a_q > mxu_q;
  assign c_lt = $signed(s1_c_q) < $signed(mns_q);
  assign c_gt = $signed(s1_c_q) > $signed(mxs_q);

  always_comb begin
    state_d = state_q;
    mnu_d   = mnu_q;
    mxu_d   = mxu_q;
    mns_d   = mns_q;
    mxs_d   = mxs_q;
    cnt_d   = cnt_q;
`ifdef MINMAX_INDEX_EN
    imnu_d  = imnu_q;
    imxu_d  = imxu_q;
    imns_d  = imns_q;
    imxs_d  = imxs_q;
`endif
    if (s1_vld_q) begin
      unique case (state_q)
        ST_EMPTY: begin
          // first sample seeds every accumulator
          mnu_d = s1_a_q;
          mxu_d = s1_a_q;
          mns_d = s1_c_q;
          mxs_d = s1_c_q;
          cnt_d = CNT_ONE;
`ifdef MINMAX_INDEX_EN
          imnu_d = '0;
          imxu_d = '0;
          imns_d = '0;
          imxs_d = '0;
`endif
        end
        ST_ACTIVE: begin
          if (a_lt) mnu_d = s1_a_q;
          if (a_gt) mxu_d = s1_a_q;
          if (c_lt) mns_d = s1_c_q;
          if (c_gt) mxs_d = s1_c_q;
          cnt_d = cnt_q + CNT_ONE;
`ifdef MINMAX_INDEX_EN
          // index of this sample is the count before it
          if (a_lt) imnu_d = cnt_q;
          if (a_gt) imxu_d = cnt_q;
          if (c_lt) imns_d = cnt_q;
          if (c_gt) imxs_d = cnt_q;
`endif
        end
        default: begin
          // saturated: extremes still track, count and
          // indices stay frozen
          if (a_lt) mnu_d = s1_a_q;
          if (a_gt) mxu_d = s1_a_q;
          if (c_lt) mns_d = s1_c_q;
          if (c_gt) mxs_d = s1_c_q;
        end
      endcase
      state_d = (cnt_d == CNT_MAX) ? ST_SAT : ST_ACTIVE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      state_q <= ST_EMPTY;
      mnu_q   <= UMIN_INIT;
      mxu_q   <= UMAX_INIT;
      mns_q   <= SMIN_INIT;
      mxs_q   <= SMAX_INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      mnu_q   <= mnu_d;
      mxu_q   <= mxu_d;
      mns_q   <= mns_d;
      mxs_q   <= mxs_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef MINMAX_INDEX_EN
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      imnu_q <= '0;
      imxu_q <= '0;
      imns_q <= '0;
      imxs_q <= '0;
    end else begin
      imnu_q <= imnu_d;
      imxu_q <= imxu_d;
      imns_q <= imns_d;
      imxs_q <= imxs_d;
    end
  end
`endif

  // ---------------- snapshot ----------------
  // Captures the registered accumulators, so pairs still in
  // S1 or being folded in this cycle are excluded.
  logic             snap_vld_q;
  logic [WIDTH-1:0] snap_mnu_q;
  logic [WIDTH-1:0] snap_mxu_q;
  logic [WIDTH-1:0] snap_mns_q;
  logic [WIDTH-1:0] snap_mxs_q;
  logic [CNT_W-1:0] snap_cnt_q;
  logic             snap_sat_q;
  logic             empty;

  assign empty = (state_q == ST_EMPTY);

  always_ff @(posedge clk) begin
    if (rst) begin
      snap_vld_q <= 1'b0;
      snap_mnu_q <= '0;
      snap_mxu_q <= '0;
      snap_mns_q <= '0;
      snap_mxs_q <= '0;
      snap_cnt_q <= '0;
      snap_sat_q <= 1'b0;
    end else if (clear) begin
      snap_vld_q <= 1'b0;
    end else if (snap_req) begin
      snap_vld_q <= 1'b1;
      // EMPTY reports zeros, not the sentinels
      snap_mnu_q <= empty ? '0 : mnu_q;
      snap_mxu_q <= empty ? '0 : mxu_q;
      snap_mns_q <= empty ? '0 : mns_q;
      snap_mxs_q <= empty ? '0 : mxs_q;
      snap_cnt_q <= cnt_q;
      snap_sat_q <= (state_q == ST_SAT);
    end
  end

  assign snap_valid = snap_vld_q;
  assign min_u      = snap_mnu_q;
  assign max_u      = snap_mxu_q;
  assign min_s      = snap_mns_q;
  assign max_s      = snap_mxs_q;
  assign count      = snap_cnt_q;
  assign sat        = snap_sat_q;

`ifdef MINMAX_INDEX_EN
  logic [CNT_W-1:0] snap_imnu_q;
  logic [CNT_W-1:0] snap_imxu_q;
  logic [CNT_W-1:0] snap_imns_q;
  logic [CNT_W-1:0] snap_imxs_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      snap_imnu_q <= '0;
      snap_imxu_q <= '0;
      snap_imns_q <= '0;
      snap_imxs_q <= '0;
    end else if (!clear && snap_req) begin
      snap_imnu_q <= imnu_q;
      snap_imxu_q <= imxu_q;
      snap_imns_q <= imns_q;
      snap_imxs_q <= imxs_q;
    end
  end

  assign idx_min_u = snap_imnu_q;
  assign idx_max_u = snap_imxu_q;
  assign idx_min_s = snap_imns_q;
  assign idx_max_s = snap_imxs_q;
`endif

endmodule

// File: tb/tb_compare_minmax_tracker.sv
// tb_compare_minmax_tracker: directed bench for compare_minmax_tracker.
// Drives a default instance and a CNT_W=4 instance from the same stimulus.

module tb_compare_minmax_tracker;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        clear;
  logic        snap_req;
  logic [63:0] in_a;
  logic [63:0] in_c;

  logic        rdy, sv, sat;
  logic [63:0] mnu, mxu, mns, mxs;
  logic [15:0] cnt;

  logic        rdy4, sv4, sat4;
  logic [63:0] mnu4, mxu4, mns4, mxs4;
  logic [3:0]  cnt4;

`ifdef MINMAX_INDEX_EN
  logic [15:0] imnu, imxu, imns, imxs;
  logic [3:0]  imnu4, imxu4, imns4, imxs4;
`endif

  int total;
  int bad;

  always #5 clk = ~clk;

  compare_minmax_tracker dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(rdy),
    .in_a(in_a), .in_c(in_c),
    .clear(clear), .snap_req(snap_req),
    .snap_valid(sv),
    .min_u(mnu), .max_u(mxu),
    .min_s(mns), .max_s(mxs),
    .count(cnt), .sat(sat)
`ifdef MINMAX_INDEX_EN
    , .idx_min_u(imnu), .idx_max_u(imxu)
    , .idx_min_s(imns), .idx_max_s(imxs)
`endif
  );

  compare_minmax_tracker #(.WIDTH(64), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(rdy4),
    .in_a(in_a), .in_c(in_c),
    .clear(clear), .snap_req(snap_req),
    .snap_valid(sv4),
    .min_u(mnu4), .max_u(mxu4),
    .min_s(mns4), .max_s(mxs4),
    .count(cnt4), .sat(sat4)
`ifdef MINMAX_INDEX_EN
    , .idx_min_u(imnu4), .idx_max_u(imxu4)
    , .idx_min_s(imns4), .idx_max_s(imxs4)
`endif
  );

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [63:0] a,
                      input logic [63:0] c);
    in_valid = 1'b1;
    in_a     = a;
    in_c     = c;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic snap();
    snap_req = 1'b1;
    tick();
    snap_req = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    total    = 0;
    bad      = 0;
    rst      = 1'b1;
    in_valid = 1'b0;
    clear    = 1'b0;
    snap_req = 1'b0;
    in_a     = '0;
    in_c     = '0;

    // 1: reset, then empty snapshot
    tick();
    tick();
    check("rst_ready", rdy, 0);
    check("rst_sv", sv, 0);
    check("rst_cnt", cnt, 0);
    check("rst_maxu", mxu, 0);
    rst = 1'b0;
    #1;
    check("ready_after_rst", rdy, 1);
    snap();
    check("t1_sv", sv, 1);
    check("t1_cnt", cnt, 0);
    check("t1_minu", mnu, 0);
    check("t1_maxu", mxu, 0);
    check("t1_mins", mns, 0);
    check("t1_maxs", mxs, 0);
    check("t1_sat", sat, 0);

    // 2: three back-to-back pairs
    push(64'd5, -64'sd2);
    push(64'd3, 64'sd7);
    push(64'd9, -64'sd8);
    tick();
    tick();
    snap();
    check("t2_minu", mnu, 64'd3);
    check("t2_maxu", mxu, 64'd9);
    check("t2_mins", mns, -64'sd8);
    check("t2_maxs", mxs, 64'sd7);
    check("t2_cnt", cnt, 3);
`ifdef MINMAX_INDEX_EN
    check("t2_iminu", imnu, 1);
    check("t2_imaxu", imxu, 2);
    check("t2_imins", imns, 2);
    check("t2_imaxs", imxs, 1);
`endif

    // 3: same bit pattern, signed vs unsigned
    do_clear();
    push(64'hFFFF_FFFF_FFFF_FFFF, -64'sd1);
    push(64'd1, 64'sd1);
    tick();
    tick();
    snap();
    check("t3_maxu", mxu, 64'hFFFF_FFFF_FFFF_FFFF);
    check("t3_minu", mnu, 64'd1);
    check("t3_mins", mns, -64'sd1);
    check("t3_maxs", mxs, 64'sd1);
    check("t3_cnt", cnt, 2);
`ifdef MINMAX_INDEX_EN
    check("t3_iminu", imnu, 1);
    check("t3_imaxu", imxu, 0);
    check("t3_imins", imns, 0);
    check("t3_imaxs", imxs, 1);
`endif

    // 4: in-flight exclusion; tie on min_u and max_s
    push(64'd1, 64'sd1);
    snap();
    check("t4_cnt_inflight", cnt, 2);
    snap();
    check("t4_cnt_next", cnt, 3);
    tick();
    snap();
    check("t4_cnt_later", cnt, 3);
    check("t4_minu", mnu, 64'd1);
    check("t4_maxs", mxs, 64'sd1);
`ifdef MINMAX_INDEX_EN
    check("t4_iminu_tie", imnu, 1);
    check("t4_imaxs_tie", imxs, 1);
`endif

    // 5: saturation on the CNT_W=4 instance
    do_clear();
    in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      in_a = 64'(i);
      in_c = 64'(i);
      tick();
    end
    in_valid = 1'b0;
    tick();
    tick();
    snap();
    check("t5_cnt4", cnt4, 15);
    check("t5_sat4", sat4, 1);
    check("t5_maxu4", mxu4, 64'd19);
    check("t5_minu4", mnu4, 64'd0);
    check("t5_cnt", cnt, 20);
    check("t5_sat", sat, 0);
    check("t5_maxs", mxs, 64'sd19);
`ifdef MINMAX_INDEX_EN
    check("t5_imaxu4", imxu4, 14);
    check("t5_iminu4", imnu4, 0);
    check("t5_imaxu", imxu, 19);
`endif

    // 6a: clear with accept + snap_req, pair in S1
    push(64'd50, 64'sd50);
    clear    = 1'b1;
    in_valid = 1'b1;
    in_a     = 64'd77;
    in_c     = 64'sd77;
    snap_req = 1'b1;
    #1;
    check("t6_clr_ready0", rdy, 0);
    tick();
    clear    = 1'b0;
    in_valid = 1'b0;
    snap_req = 1'b0;
    #1;
    check("t6_clr_ready1", rdy, 0);
    check("t6_clr_sv", sv, 0);
    tick();
    check("t6_clr_ready2", rdy, 1);
    tick();
    snap();
    check("t6_clr_snap_sv", sv, 1);
    check("t6_clr_cnt", cnt, 0);
    check("t6_clr_maxu", mxu, 0);
    check("t6_clr_mins", mns, 0);

    // 6b: same with rst, outputs also zeroed
    push(64'd60, -64'sd60);
    tick();
    tick();
    snap();
    check("t6_pre_cnt", cnt, 1);
    check("t6_pre_maxu", mxu, 64'd60);
    push(64'd61, 64'sd61);
    rst      = 1'b1;
    in_valid = 1'b1;
    snap_req = 1'b1;
    #1;
    check("t6_rst_ready0", rdy, 0);
    tick();
    rst      = 1'b0;
    in_valid = 1'b0;
    snap_req = 1'b0;
    #1;
    check("t6_rst_sv", sv, 0);
    check("t6_rst_maxu", mxu, 0);
    check("t6_rst_mins", mns, 0);
    check("t6_rst_cnt", cnt, 0);
    check("t6_rst_ready1", rdy, 1);
    tick();
    tick();
    snap();
    check("t6_rst_snap_sv", sv, 1);
    check("t6_rst_snap_cnt", cnt, 0);
    check("t6_rst_snap_maxu", mxu, 0);
    check("t6_rst_snap_maxs", mxs, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
